jk_bank_arbiter: RTL and testbench

Shared controller for a bank of clocked JK storage bits. Up to NREQ requesters submit JK commands (hold/clear/set/toggle) with a bit index and a burst length. A round-robin arbiter grants one requester at a time and applies the command to the addressed bit for 1–4 consecutive cycles. The block sits between independent control agents and the JK bit bank it owns, and exposes the bank state on `q`.

---
 rtl/jk_pkg.sv | 25 ++
 rtl/jk_bank_arbiter_if.sv | 23 ++
 rtl/jk_rr_arbiter.sv | 52 +++++
 rtl/jk_bank_arbiter.sv | 116 +++++++++++
 tb/tb_jk_bank_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/jk_pkg.sv
// Shared types and the JK next-state helper for the JK bank arbiter.
package jk_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_CLR  = 2'b01,
    OP_SET  = 2'b10,
    OP_TGL  = 2'b11
  } jk_op_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } jk_arb_state_t;

  function automatic logic jk_apply(jk_op_t op, logic b);
    case (op)
      OP_HOLD: return b;
      OP_CLR:  return 1'b0;
      OP_SET:  return 1'b1;
      default: return ~b;
    endcase
  endfunction

endpackage

// File: rtl/jk_bank_arbiter_if.sv
// Requester-side command bundle for jk_bank_arbiter; master = requesters, slave = arbiter.
interface jk_bank_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int IDXW = $clog2(WIDTH);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [2*NREQ-1:0]    req_jk;
  logic [IDXW*NREQ-1:0] req_idx;
  logic [2*NREQ-1:0]    req_len;

  modport master (
    output req_valid, req_jk, req_idx, req_len,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_jk, req_idx, req_len,
    output req_ready
  );
endinterface

// File: rtl/jk_rr_arbiter.sv
// Combinational round-robin pick with next-pointer; JK_ARB_PRIO0_EN gives requester 0 absolute priority.
module jk_rr_arbiter
  import jk_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [PW-1:0]   win,
  output logic            any,
  output logic [PW-1:0]   ptr_next
);

  int unsigned cand;

  always_comb begin
    onehot   = '0;
    win      = '0;
    any      = 1'b0;
    ptr_next = ptr;
    cand     = 0;
`ifdef JK_ARB_PRIO0_EN
    // Requester 0 pre-empts; the pointer only ever walks 1..NREQ-1.
    if (valid[0]) begin
      onehot[0] = 1'b1;
      any       = 1'b1;
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = (32'(ptr) + i) % NREQ;
      if (!any && cand != 0 && valid[cand]) begin
        onehot[cand] = 1'b1;
        win          = PW'(cand);
        any          = 1'b1;
        ptr_next     = (cand == NREQ - 1) ? PW'(1) : PW'(cand + 1);
      end
    end
`else
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = (32'(ptr) + i) % NREQ;
      if (!any && valid[cand]) begin
        onehot[cand] = 1'b1;
        win          = PW'(cand);
        any          = 1'b1;
        ptr_next     = (cand == NREQ - 1) ? '0 : PW'(cand + 1);
      end
    end
`endif
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter owning a bank of JK bits; applies 1-4 cycle command bursts.
// Optional build macro: JK_ARB_PRIO0_EN (requester 0 absolute priority, handled in jk_rr_arbiter).
module jk_bank_arbiter
  import jk_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  jk_bank_arbiter_if.slave  bus,
  output logic [WIDTH-1:0]  q,
  output logic [NREQ-1:0]   grant,
  output logic              idx_err
);

  localparam int IDXW = $clog2(WIDTH);
  localparam int PW   = $clog2(NREQ);

  jk_arb_state_t    state_q, state_d;
  jk_op_t           op_q, op_d, in_op;
  logic [IDXW-1:0]  idx_q, idx_d, in_idx;
  logic [1:0]       rem_q, rem_d, in_len;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [PW-1:0]    rr_q, rr_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             err_q, err_d;
  logic [NREQ-1:0]  ready;
  logic             xfer;

  logic [NREQ-1:0]  win_oh;
  logic [PW-1:0]    win_idx, win_ptr_next;
  logic             win_any;

  jk_rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .valid    (bus.req_valid),
    .ptr      (rr_q),
    .onehot   (win_oh),
    .win      (win_idx),
    .any      (win_any),
    .ptr_next (win_ptr_next)
  );

  assign ready         = (state_q == ST_IDLE && !rst) ? win_oh : '0;
  assign xfer          = win_any && (|(bus.req_valid & ready));
  assign in_op         = jk_op_t'(bus.req_jk[2*int'(win_idx) +: 2]);
  assign in_idx        = bus.req_idx[IDXW*int'(win_idx) +: IDXW];
  assign in_len        = bus.req_len[2*int'(win_idx) +: 2];
  assign bus.req_ready = ready;
  assign q             = q_q;
  assign grant         = grant_q;
  assign idx_err       = err_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    q_d     = q_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (xfer) begin
          op_d    = in_op;
          idx_d   = in_idx;
          rem_d   = in_len;
          grant_d = win_oh;
          rr_d    = win_ptr_next;
          if (int'(in_idx) < WIDTH) q_d[in_idx] = jk_apply(in_op, q_q[in_idx]);
          else                      err_d = 1'b1;
          if (in_len != 2'd0) state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        // rem_q holds edges still to apply after the transfer edge.
        if (int'(idx_q) < WIDTH) q_d[idx_q] = jk_apply(op_q, q_q[idx_q]);
        if (rem_q == 2'd1) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else begin
          rem_d = rem_q - 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_HOLD;
      idx_q   <= '0;
      rem_q   <= '0;
      grant_q <= '0;
      rr_q    <= '0;
      q_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      q_q     <= q_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter (8-bit/4-requester and 6-bit/2-requester instances).
module tb_jk_bank_arbiter;

  localparam int S_RDY = 0, S_Q = 1, S_GNT = 2, S_ERR = 3;
  localparam int S_RDY6 = 4, S_Q6 = 5, S_GNT6 = 6, S_ERR6 = 7;

  typedef struct {
    string       tag;
    int unsigned phase;
    int unsigned sig;
    logic [31:0] val;
  } exp_t;

  logic clk, rst;
  logic [7:0] q8;
  logic [3:0] grant8;
  logic       err8;
  logic [5:0] q6;
  logic [1:0] grant6;
  logic       err6;
  logic [7:0] qb;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  jk_bank_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();
  jk_bank_arbiter_if #(.NREQ(2), .WIDTH(6)) bus6 ();

  jk_bank_arbiter #(.NREQ(4), .WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .q(q8), .grant(grant8), .idx_err(err8)
  );

  jk_bank_arbiter #(.NREQ(2), .WIDTH(6)) u_dut6 (
    .clk(clk), .rst(rst), .bus(bus6), .q(q6), .grant(grant6), .idx_err(err6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] sample(input int unsigned s);
    case (s)
      S_RDY:   return 32'(bus.req_ready);
      S_Q:     return 32'(q8);
      S_GNT:   return 32'(grant8);
      S_ERR:   return 32'(err8);
      S_RDY6:  return 32'(bus6.req_ready);
      S_Q6:    return 32'(q6);
      S_GNT6:  return 32'(grant6);
      default: return 32'(err6);
    endcase
  endfunction

  task automatic push(input string t, input int unsigned ph, input int unsigned s, input logic [31:0] v);
    exp_t e;
    e.tag = t; e.phase = ph; e.sig = s; e.val = v;
    sbq.push_back(e);
  endtask

  // Phase 0 items are combinational (before the edge); phase 1 items are registered results.
  task automatic step();
    exp_t e;
    #1;
    while (sbq.size() > 0 && sbq[0].phase == 0) begin
      e = sbq.pop_front();
      check(e.tag, sample(e.sig), e.val);
    end
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.tag, sample(e.sig), e.val);
    end
  endtask

  task automatic cyc(input string t, input logic [3:0] rdy, input logic [7:0] qv, input logic [3:0] g);
    push({t, "_rdy"}, 0, S_RDY, 32'(rdy));
    push({t, "_q"},   1, S_Q,   32'(qv));
    push({t, "_gnt"}, 1, S_GNT, 32'(g));
    push({t, "_err"}, 1, S_ERR, 32'd0);
    step();
  endtask

  task automatic cyc6(input string t, input logic [1:0] rdy, input logic [5:0] qv, input logic [1:0] g,
                      input logic e);
    push({t, "_rdy6"}, 0, S_RDY6, 32'(rdy));
    push({t, "_q6"},   1, S_Q6,   32'(qv));
    push({t, "_gnt6"}, 1, S_GNT6, 32'(g));
    push({t, "_err6"}, 1, S_ERR6, 32'(e));
    step();
  endtask

  task automatic set_cmd(input int i, input logic [1:0] jk, input logic [2:0] idx, input logic [1:0] len);
    bus.req_jk[2*i +: 2]  = jk;
    bus.req_idx[3*i +: 3] = idx;
    bus.req_len[2*i +: 2] = len;
  endtask

  task automatic set_cmd6(input int i, input logic [1:0] jk, input logic [2:0] idx, input logic [1:0] len);
    bus6.req_jk[2*i +: 2]  = jk;
    bus6.req_idx[3*i +: 3] = idx;
    bus6.req_len[2*i +: 2] = len;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.req_valid  = 4'hF;
    bus.req_jk     = '0;
    bus.req_idx    = '0;
    bus.req_len    = '0;
    bus6.req_valid = '0;
    bus6.req_jk    = '0;
    bus6.req_idx   = '0;
    bus6.req_len   = '0;

    // Reset with every requester valid: nothing is ready or granted.
    push("rst_q6", 1, S_Q6, 32'd0);
    push("rst_err6", 1, S_ERR6, 32'd0);
    cyc("rst0", 4'h0, 8'h00, 4'h0);
    cyc("rst1", 4'h0, 8'h00, 4'h0);
    rst = 1'b0;

    cyc("first", 4'h1, 8'h00, 4'h1);
    bus.req_valid = 4'h0;

    set_cmd(1, 2'b10, 3'd3, 2'd0);
    bus.req_valid = 4'h2;
    cyc("set", 4'h2, 8'h08, 4'h2);

    set_cmd(2, 2'b11, 3'd3, 2'd0);
    bus.req_valid = 4'h4;
    cyc("tgl", 4'h4, 8'h00, 4'h4);

    set_cmd(3, 2'b11, 3'd0, 2'd2);
    bus.req_valid = 4'h8;
    cyc("tburst0", 4'h8, 8'h01, 4'h8);
    for (int i = 0; i < 4; i++) set_cmd(i, 2'b10, 3'(i), 2'd0);
    bus.req_valid = 4'hF;
    cyc("tburst1", 4'h0, 8'h00, 4'h8);
    cyc("tburst2", 4'h0, 8'h01, 4'h0);

`ifdef JK_ARB_PRIO0_EN
    cyc("rr0", 4'h1, 8'h01, 4'h1);
    cyc("rr1", 4'h1, 8'h01, 4'h1);
    cyc("rr2", 4'h1, 8'h01, 4'h1);
    cyc("rr3", 4'h1, 8'h01, 4'h1);
    cyc("rr4", 4'h1, 8'h01, 4'h1);
    qb = 8'h01;
`else
    cyc("rr0", 4'h1, 8'h01, 4'h1);
    cyc("rr1", 4'h2, 8'h03, 4'h2);
    cyc("rr2", 4'h4, 8'h07, 4'h4);
    cyc("rr3", 4'h8, 8'h0F, 4'h8);
    cyc("rr4", 4'h1, 8'h0F, 4'h1);
    qb = 8'h0F;
`endif
    bus.req_valid = 4'h0;
    cyc("idle0", 4'h0, qb, 4'h0);

    // A 4-cycle hold reserves the bank; req1 waits until the edge after it.
    set_cmd(0, 2'b00, 3'd2, 2'd3);
    bus.req_valid = 4'h1;
    cyc("hold0", 4'h1, qb, 4'h1);
    set_cmd(1, 2'b10, 3'd4, 2'd0);
    bus.req_valid = 4'h2;
    cyc("hold1", 4'h0, qb, 4'h1);
    cyc("hold2", 4'h0, qb, 4'h1);
    cyc("hold3", 4'h0, qb, 4'h0);
    qb = qb | 8'h10;
    cyc("afterhold", 4'h2, qb, 4'h2);
    bus.req_valid = 4'h0;

    // Reset in the middle of a toggle burst.
    set_cmd(2, 2'b11, 3'd5, 2'd3);
    bus.req_valid = 4'h4;
    cyc("rb0", 4'h4, qb | 8'h20, 4'h4);
    bus.req_valid = 4'h0;
    cyc("rb1", 4'h0, qb, 4'h4);
    rst = 1'b1;
    cyc("rbrst", 4'h0, 8'h00, 4'h0);
    rst = 1'b0;
    set_cmd(0, 2'b10, 3'd1, 2'd0);
    bus.req_valid = 4'h1;
    cyc("postrst", 4'h1, 8'h02, 4'h1);
    bus.req_valid = 4'h0;
    cyc("idle1", 4'h0, 8'h02, 4'h0);

    // Out-of-range index on the 6-bit bank.
    set_cmd6(1, 2'b10, 3'd7, 2'd1);
    bus6.req_valid = 2'b10;
    cyc6("ie0", 2'b10, 6'h00, 2'b10, 1'b1);
    set_cmd6(0, 2'b10, 3'd5, 2'd0);
    bus6.req_valid = 2'b01;
    cyc6("ie1", 2'b00, 6'h00, 2'b00, 1'b0);
    cyc6("ie2", 2'b01, 6'h20, 2'b01, 1'b0);
    bus6.req_valid = 2'b00;
    cyc6("ie3", 2'b00, 6'h20, 2'b00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
